// File: rtl/dc_motor_pwm_gen.sv
// PWM source for the DC motor H-bridge driver: prescaled timebase, period-aligned
// duty updates and a soft-start / soft-stop ramp controller.
module dc_motor_pwm_gen #(
    parameter int PRESCALE     = 50,
    parameter int RAMP_STEP    = 1,
    parameter int RAMP_PERIODS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] duty_cmd,
    output logic       pulse,
    output logic       motor_off,
    output logic [7:0] duty_cur,
    output logic       period_end,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP     = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(RAMP_PERIODS - 1);
    localparam logic signed [8:0] STEP = 9'(RAMP_STEP);

    state_t st, st_next;

    logic [PW-1:0]      pre;
    logic [7:0]         cnt, cnt_next;
    logic [7:0]         target, target_next;
    logic [7:0]         duty_act, duty_act_next;
    logic [7:0]         duty_cur_next;
    logic [RW-1:0]      rcnt, rcnt_next;
    logic               tick;
    logic               step_en;
    logic               motor_off_next;
    logic signed [8:0]  diff;

    assign state = st;

    assign tick       = (pre == PRE_LAST);
    assign period_end = tick && (cnt == 8'hFF);
    assign cnt_next   = tick ? cnt + 8'd1 : cnt;
    assign step_en    = period_end && (rcnt == RCNT_LAST);

    // Both operands are zero-extended so the distance is exact in 9-bit signed.
    assign diff = $signed({1'b0, target}) - $signed({1'b0, duty_cur});

    always_comb begin
        duty_cur_next = duty_cur;
        if (step_en) begin
            if (diff > STEP)
                duty_cur_next = duty_cur + STEP[7:0];
            else if (diff < -STEP)
                duty_cur_next = duty_cur - STEP[7:0];
            else
                duty_cur_next = target;
        end
    end

    always_comb begin
        st_next        = st;
        motor_off_next = motor_off;
        rcnt_next      = rcnt;
        if (period_end)
            rcnt_next = (rcnt == RCNT_LAST) ? '0 : rcnt + RW'(1);
        case (st)
            IDLE: begin
                if (!stop && start && (duty_cmd != 8'd0)) begin
                    st_next        = RAMP;
                    rcnt_next      = '0;
                    motor_off_next = 1'b0;
                end
            end
            RAMP: begin
                if (stop)
                    st_next = STOPPING;
                else if (duty_cur == target)
                    st_next = RUN;
            end
            RUN: begin
                if (stop)
                    st_next = STOPPING;
                else if (duty_cmd != duty_cur)
                    st_next = RAMP;
            end
            STOPPING: begin
                // Leave on the very edge the ramp lands on zero.
                if (period_end && (duty_cur_next == 8'd0)) begin
                    st_next        = IDLE;
                    motor_off_next = 1'b1;
                end
            end
            default: st_next = IDLE;
        endcase
    end

    assign target_next   = ((st_next == RAMP) || (st_next == RUN)) ? duty_cmd : 8'd0;
    assign duty_act_next = period_end ? duty_cur_next : duty_act;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre       <= '0;
            cnt       <= 8'd0;
            rcnt      <= '0;
            st        <= IDLE;
            motor_off <= 1'b1;
            target    <= 8'd0;
            duty_cur  <= 8'd0;
            duty_act  <= 8'd0;
            pulse     <= 1'b0;
        end else begin
            pre       <= tick ? '0 : pre + PW'(1);
            cnt       <= cnt_next;
            rcnt      <= rcnt_next;
            st        <= st_next;
            motor_off <= motor_off_next;
            target    <= target_next;
            duty_cur  <= duty_cur_next;
            duty_act  <= duty_act_next;
            pulse     <= (cnt_next < duty_act_next) && !motor_off_next;
        end
    end

endmodule

// File: tb/tb_dc_motor_pwm_gen.sv
// Bench for dc_motor_pwm_gen: directed scenarios on two parameter sets plus a
// randomized run against a time-based behavioural model.
module tb_dc_motor_pwm_gen;

    localparam int R_P  = 3;
    localparam int R_S  = 37;
    localparam int R_RP = 3;

    logic clock, reset;
    logic start, stop;
    logic [7:0] duty_cmd;
    logic pulse, motor_off, period_end;
    logic [7:0] duty_cur;
    logic [1:0] state;

    logic x_start, x_stop;
    logic [7:0] x_duty;
    logic x_pulse, x_off, x_period_end;
    logic [7:0] x_cur;
    logic [1:0] x_state;

    logic r_start, r_stop;
    logic [7:0] r_duty;
    logic r_pulse, r_off, r_period_end;
    logic [7:0] r_cur;
    logic [1:0] r_state;

    int n_cmp = 0;
    int n_bad = 0;

    // model state for the randomized run
    int m_t, m_state, m_off, m_cur, m_act, m_target, m_rcnt, m_pulse;

    dc_motor_pwm_gen #(.PRESCALE(2), .RAMP_STEP(64), .RAMP_PERIODS(1)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .duty_cmd(duty_cmd),
        .pulse(pulse), .motor_off(motor_off), .duty_cur(duty_cur),
        .period_end(period_end), .state(state));

    dc_motor_pwm_gen #(.PRESCALE(1), .RAMP_STEP(255), .RAMP_PERIODS(1)) dut_x (
        .clock(clock), .reset(reset), .start(x_start), .stop(x_stop), .duty_cmd(x_duty),
        .pulse(x_pulse), .motor_off(x_off), .duty_cur(x_cur),
        .period_end(x_period_end), .state(x_state));

    dc_motor_pwm_gen #(.PRESCALE(R_P), .RAMP_STEP(R_S), .RAMP_PERIODS(R_RP)) dut_r (
        .clock(clock), .reset(reset), .start(r_start), .stop(r_stop), .duty_cmd(r_duty),
        .pulse(r_pulse), .motor_off(r_off), .duty_cur(r_cur),
        .period_end(r_period_end), .state(r_state));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        start = 0; stop = 0; duty_cmd = 0;
        x_start = 0; x_stop = 0; x_duty = 0;
        r_start = 0; r_stop = 0; r_duty = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Bounded wait for a period_end sample; a timeout is a failure.
    task automatic wait_pe(input int which, output bit ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if ((which == 0 && period_end) || (which == 1 && x_period_end)) begin
                ok = 1;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_period_end timeout on instance %0d", which);
    endtask

    task automatic pulse_start(input logic [7:0] dc);
        @(negedge clock);
        duty_cmd = dc;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        int bad_hold;
        do_reset();
        n_cmp++;
        if (motor_off !== 1'b1 || state !== 2'd0 || pulse !== 1'b0 || duty_cur !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_initial got off=%b st=%0d pulse=%b cur=%0d want 1/0/0/0",
                     motor_off, state, pulse, duty_cur);
        end
        pulse_start(8'd200);
        wait_pe(0, ok);
        wait_pe(0, ok);
        @(posedge clock);
        #2;
        n_cmp++;
        if (duty_cur !== 8'd128) begin
            n_bad++;
            $display("FAIL reset_precondition duty_cur got %0d want 128", duty_cur);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (pulse !== 1'b0 || motor_off !== 1'b1 || duty_cur !== 8'd0 ||
            period_end !== 1'b0 || state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_async got pulse=%b off=%b cur=%0d pe=%b st=%0d want 0/1/0/0/0",
                     pulse, motor_off, duty_cur, period_end, state);
        end
        @(negedge clock);
        reset = 1'b1;
        bad_hold = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clock);
            if (motor_off !== 1'b1 || state !== 2'd0 || pulse !== 1'b0) bad_hold++;
        end
        n_cmp++;
        if (bad_hold != 0) begin
            n_bad++;
            $display("FAIL reset_release_hold bad samples %0d want 0", bad_hold);
        end
    endtask

    task automatic test_soft_start();
        bit ok;
        int hi;
        logic [7:0] exp_cur [4];
        exp_cur = '{8'd64, 8'd128, 8'd192, 8'd200};
        do_reset();
        pulse_start(8'd200);
        n_cmp++;
        if (state !== 2'd1 || motor_off !== 1'b0) begin
            n_bad++;
            $display("FAIL start_entry got st=%0d off=%b want 1/0", state, motor_off);
        end
        n_cmp++;
        if (pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL start_no_pulse got %b want 0", pulse);
        end
        for (int k = 0; k < 4; k++) begin
            wait_pe(0, ok);
            @(negedge clock);
            n_cmp++;
            if (duty_cur !== exp_cur[k]) begin
                n_bad++;
                $display("FAIL soft_start_step%0d duty_cur got %0d want %0d", k, duty_cur, exp_cur[k]);
            end
        end
        hi = pulse ? 1 : 0;
        for (int i = 1; i < 512; i++) begin
            @(negedge clock);
            if (pulse) hi++;
            if (i == 2) begin
                n_cmp++;
                if (state !== 2'd2) begin
                    n_bad++;
                    $display("FAIL soft_start_run state got %0d want 2", state);
                end
            end
            if (i == 511) begin
                n_cmp++;
                if (period_end !== 1'b1) begin
                    n_bad++;
                    $display("FAIL period_length period_end got %b want 1", period_end);
                end
            end
        end
        n_cmp++;
        if (hi != 400) begin
            n_bad++;
            $display("FAIL soft_start_high_time got %0d want 400", hi);
        end
    endtask

    task automatic test_soft_stop();
        bit ok;
        logic [7:0] exp_cur [4];
        exp_cur = '{8'd136, 8'd72, 8'd8, 8'd0};
        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_cmp++;
        if (state !== 2'd3) begin
            n_bad++;
            $display("FAIL stop_entry state got %0d want 3", state);
        end
        for (int k = 0; k < 4; k++) begin
            wait_pe(0, ok);
            @(negedge clock);
            n_cmp++;
            if (duty_cur !== exp_cur[k]) begin
                n_bad++;
                $display("FAIL soft_stop_step%0d duty_cur got %0d want %0d", k, duty_cur, exp_cur[k]);
            end
            n_cmp++;
            if (k < 3 && (state !== 2'd3 || motor_off !== 1'b0)) begin
                n_bad++;
                $display("FAIL soft_stop_mid%0d got st=%0d off=%b want 3/0", k, state, motor_off);
            end else if (k == 3 && (state !== 2'd0 || motor_off !== 1'b1 || pulse !== 1'b0)) begin
                n_bad++;
                $display("FAIL soft_stop_end got st=%0d off=%b pulse=%b want 0/1/0",
                         state, motor_off, pulse);
            end
        end
    endtask

    task automatic test_requests();
        bit ok;
        @(negedge clock);
        duty_cmd = 8'd100; start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (state !== 2'd0 || motor_off !== 1'b1) begin
            n_bad++;
            $display("FAIL start_and_stop got st=%0d off=%b want 0/1", state, motor_off);
        end
        pulse_start(8'd0);
        n_cmp++;
        if (state !== 2'd0 || motor_off !== 1'b1) begin
            n_bad++;
            $display("FAIL start_zero_duty got st=%0d off=%b want 0/1", state, motor_off);
        end
        pulse_start(8'd64);
        wait_pe(0, ok);
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (state !== 2'd2 || duty_cur !== 8'd64) begin
            n_bad++;
            $display("FAIL small_ramp got st=%0d cur=%0d want 2/64", state, duty_cur);
        end
        @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        pulse_start(8'd64);
        n_cmp++;
        if (state !== 2'd3 || motor_off !== 1'b0) begin
            n_bad++;
            $display("FAIL start_in_stopping got st=%0d off=%b want 3/0", state, motor_off);
        end
        wait_pe(0, ok);
        @(negedge clock);
        n_cmp++;
        if (state !== 2'd0 || duty_cur !== 8'd0 || motor_off !== 1'b1) begin
            n_bad++;
            $display("FAIL stopping_to_idle got st=%0d cur=%0d off=%b want 0/0/1",
                     state, duty_cur, motor_off);
        end
    endtask

    task automatic test_midperiod();
        bit ok;
        int hi;
        logic [7:0] exp_cur [3];
        exp_cur = '{8'd136, 8'd72, 8'd50};
        do_reset();
        pulse_start(8'd200);
        for (int k = 0; k < 4; k++) wait_pe(0, ok);
        @(negedge clock);
        @(negedge clock);
        n_cmp++;
        if (state !== 2'd2) begin
            n_bad++;
            $display("FAIL mid_precondition state got %0d want 2", state);
        end
        wait_pe(0, ok);
        hi = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clock);
            if (i == 200) duty_cmd = 8'd50;
            if (pulse) hi++;
            if (i == 202) begin
                n_cmp++;
                if (state !== 2'd1) begin
                    n_bad++;
                    $display("FAIL mid_to_ramp state got %0d want 1", state);
                end
            end
        end
        n_cmp++;
        if (hi != 400) begin
            n_bad++;
            $display("FAIL mid_period_width got %0d want 400", hi);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_pe(0, ok);
            @(negedge clock);
            n_cmp++;
            if (duty_cur !== exp_cur[k]) begin
                n_bad++;
                $display("FAIL mid_ramp_step%0d duty_cur got %0d want %0d", k, duty_cur, exp_cur[k]);
            end
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int lo, lo_at;
        do_reset();
        @(negedge clock);
        x_duty = 8'd255; x_start = 1'b1;
        @(negedge clock);
        x_start = 1'b0;
        n_cmp++;
        if (x_state !== 2'd1 || x_off !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_entry got st=%0d off=%b want 1/0", x_state, x_off);
        end
        wait_pe(1, ok);
        @(negedge clock);
        n_cmp++;
        if (x_cur !== 8'd255) begin
            n_bad++;
            $display("FAIL ext_full_step duty_cur got %0d want 255", x_cur);
        end
        lo = 0;
        lo_at = -1;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clock);
            if (!x_pulse) begin
                lo++;
                lo_at = i;
            end
            if (i == 255) begin
                n_cmp++;
                if (x_period_end !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ext_period_256 period_end got %b want 1", x_period_end);
                end
            end
        end
        n_cmp++;
        if (lo != 1 || lo_at != 255) begin
            n_bad++;
            $display("FAIL ext_low_time got %0d low at %0d want 1 low at 255", lo, lo_at);
        end
    endtask

    // Behavioural reference: the timebase is derived from elapsed clocks since
    // reset, and the ramp/FSM rules are applied once per clock.
    task automatic model_step(input bit st, input bit sp, input int dc);
        bit pe;
        int ncur, nr, ns, noff, d;
        pe = ((m_t % R_P) == R_P - 1) && (((m_t / R_P) % 256) == 255);
        ncur = m_cur;
        if (pe && m_rcnt == R_RP - 1) begin
            d = m_target - m_cur;
            if (d > R_S) ncur = m_cur + R_S;
            else if (d < -R_S) ncur = m_cur - R_S;
            else ncur = m_target;
        end
        nr = pe ? ((m_rcnt == R_RP - 1) ? 0 : m_rcnt + 1) : m_rcnt;
        ns = m_state;
        noff = m_off;
        if (m_state == 0 && !sp && st && dc != 0) begin
            ns = 1; nr = 0; noff = 0;
        end else if (m_state == 1 || m_state == 2) begin
            if (sp) ns = 3;
            else if (m_state == 1 && m_cur == m_target) ns = 2;
            else if (m_state == 2 && dc != m_cur) ns = 1;
        end else if (m_state == 3 && pe && ncur == 0) begin
            ns = 0; noff = 1;
        end
        m_target = (ns == 1 || ns == 2) ? dc : 0;
        if (pe) m_act = ncur;
        m_t++;
        m_pulse = ((((m_t / R_P) % 256) < m_act) && noff == 0) ? 1 : 0;
        m_cur = ncur;
        m_rcnt = nr;
        m_state = ns;
        m_off = noff;
    endtask

    task automatic test_random();
        int shown, v;
        bit m_pe;
        shown = 0;
        @(negedge clock);
        reset = 1'b0;
        r_start = 0; r_stop = 0; r_duty = 8'd0;
        m_t = 0; m_state = 0; m_off = 1; m_cur = 0; m_act = 0;
        m_target = 0; m_rcnt = 0; m_pulse = 0;
        @(negedge clock);
        reset = 1'b1;
        r_duty = 8'($urandom_range(1, 255));
        model_step(1'b0, 1'b0, int'(r_duty));
        for (int c = 0; c < 45000; c++) begin
            @(negedge clock);
            m_pe = ((m_t % R_P) == R_P - 1) && (((m_t / R_P) % 256) == 255);
            n_cmp++;
            if (r_pulse !== m_pulse[0] || r_off !== m_off[0] || r_cur !== 8'(m_cur) ||
                r_period_end !== m_pe || r_state !== 2'(m_state)) begin
                n_bad++;
                if (shown < 8) begin
                    shown++;
                    $display("FAIL random_cycle%0d got p=%b off=%b cur=%0d pe=%b st=%0d want %0d/%0d/%0d/%b/%0d",
                             c, r_pulse, r_off, r_cur, r_period_end, r_state,
                             m_pulse, m_off, m_cur, m_pe, m_state);
                end
            end
            r_start = ($urandom_range(0, 299) == 0);
            r_stop  = ($urandom_range(0, 3999) == 0);
            if ($urandom_range(0, 2999) == 0) begin
                v = $urandom_range(0, 9);
                r_duty = (v == 0) ? 8'd0 : (v == 1) ? 8'd255 : 8'($urandom_range(0, 255));
            end
            model_step(r_start, r_stop, int'(r_duty));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 0; stop = 0; duty_cmd = 0;
        x_start = 0; x_stop = 0; x_duty = 0;
        r_start = 0; r_stop = 0; r_duty = 0;
        test_reset();
        test_soft_start();
        test_soft_stop();
        test_requests();
        test_midperiod();
        test_extremes();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dc_motor_pwm_gen.md
# dc_motor_pwm_gen

PWM source for the DC motor drive stage. It turns an 8-bit speed command into the `pulse` and active-high `motor_off` signals that the downstream H-bridge driver consumes. The driver forces both bridge legs low while `motor_off` is 1, and otherwise drives `pulse` and its complement onto the two legs. The block adds a prescaled PWM timebase, glitch-free duty updates at period boundaries, and a soft-start/soft-stop ramp state machine, so the bridge never sees a duty step.

## Interface
- `PRESCALE`, default 50: clock cycles per PWM count tick, ≥1.
- `RAMP_STEP`, default 1: duty change per ramp step, 1..255.
- `RAMP_PERIODS`, default 4: PWM periods between ramp steps, ≥1.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: run request, sampled every clock.
- `stop` in 1: stop request, sampled every clock.
- `duty_cmd` in 8: target duty, 0..255; high time is `duty_cmd`/256 of the period.
- `pulse` out 1: registered PWM output to the driver stage.
- `motor_off` out 1: 1 keeps the bridge off. Connects to the driver's enable.
- `duty_cur` out 8: current ramped duty.
- `period_end` out 1: one-cycle strobe on the last clock of each PWM period.
- `state` out 2: IDLE=0, RAMP=1, RUN=2, STOPPING=3.

## Operation
- **Prescaler**: `pre` counts 0..PRESCALE-1. `tick` is high when `pre`==PRESCALE-1. The prescaler free-runs in all states.
- **PWM counter**: `cnt` (8b) increments on `tick` and wraps 255→0, giving a period of 256·PRESCALE clocks. `period_end` = `tick` && `cnt`==255.
- **Active duty register `duty_act`**:
  - Loads only on `period_end`, from the value `duty_cur` takes in that same cycle.
  - It is never changed mid-period.
- **Pulse**:
  - `pulse` <= (`cnt_next` < `duty_act_next`) && !`motor_off_next`, registered.
  - Duty 0 gives a constant 0.
  - Duty 255 is high for 255 of 256 counts.
- **Ramp**:
  - Evaluated only on `period_end`.
  - `rcnt` counts periods 0..RAMP_PERIODS-1. A step is taken on the `period_end` where `rcnt`==RAMP_PERIODS-1, and `rcnt` then clears.
  - A step moves `duty_cur` toward `target` by RAMP_STEP and never overshoots: if |`target`-`duty_cur`| < RAMP_STEP, `duty_cur` becomes `target`.
  - Step arithmetic uses 9-bit signed compare; the result is always 0..255.
- **Target**:
  - In RAMP and RUN, `target` = `duty_cmd`, sampled every clock.
  - In STOPPING and IDLE, `target` = 0.
- **FSM transitions**:
  - IDLE:
    - `stop`=0 && `start`=1 && `duty_cmd`≠0 → RAMP. `rcnt` clears and `motor_off` goes to 0.
    - `start` with `duty_cmd`=0 is ignored.
  - RAMP:
    - `duty_cur`==`target` → RUN.
    - `stop` → STOPPING.
  - RUN:
    - `duty_cmd`≠`duty_cur` → RAMP.
    - `stop` → STOPPING.
  - STOPPING:
    - `duty_cur`==0 on a `period_end` → IDLE, with `motor_off`=1.
    - `start` is ignored until IDLE is reached.
- **Priority**: `stop` beats `start` in the same cycle. `stop` beats a concurrent `duty_cmd` change.
- **RAMP with `duty_cmd`=0**: ramps down to 0, enters RUN at duty 0 with `motor_off` still 0, and `pulse` stays low.

## Timing
- **Reset values**: `pulse`=0, `motor_off`=1, `duty_cur`=0, `period_end`=0, `state`=IDLE. Internal `pre`, `cnt`, `rcnt`, `duty_act` and `target` are all 0.
- **Reset mid-operation**: all outputs return to their reset values immediately (asynchronous). Operation restarts from IDLE after release.
- **`start` → outputs**: `state`=RAMP and `motor_off`=0 on the clock edge after `start` is sampled.
  - The first nonzero `pulse` appears only after the first ramp step. That step is on the RAMP_PERIODS-th `period_end` after entry; the `cnt` phase is not reset.
- **`duty_cur` changes**: only on the clock edge of `period_end`. `duty_act` follows on the same edge.
- **`pulse`**: changes only on clock edges where `tick` is 1, or where `motor_off` changes.
- **STOPPING → IDLE**: leaves on the `period_end` where `duty_cur` becomes 0. `motor_off`=1 from that edge on.

## Test plan
Benches use PRESCALE=2, RAMP_STEP=64, RAMP_PERIODS=1 unless noted.

1. **Reset**: assert `reset`=0 mid-run at `duty_cur`=128 → all outputs take their reset values in the same cycle. After release, `motor_off` stays 1 until `start`.
2. **Soft start**: `start` pulse with `duty_cmd`=200 → `duty_cur` reads 64, 128, 192, 200 at successive `period_end`s, then `state`=RUN. In the period after `duty_cur`=200, `pulse` high time is exactly 400 clocks of 512.
3. **Soft stop**: `stop` in RUN at duty 200 → `duty_cur` reads 136, 72, 8, 0, then IDLE. `motor_off`=1 at the final `period_end`.
4. **Simultaneous and ignored requests**:
   - `start`=`stop`=1 in IDLE → stays IDLE.
   - `start` with `duty_cmd`=0 → stays IDLE.
   - `start` during STOPPING → ignored.
5. **Mid-period command change**: change `duty_cmd` 200→50 at `cnt`=100 in RUN → no change to `pulse` width in the current period. `duty_cur` then reads 136, 72, 50.
6. **Extremes**, with RAMP_STEP=255:
   - `duty_cmd`=255 → `duty_cur`=255 after one period, and `pulse` is low only while `cnt`=255.
   - PRESCALE=1 → the period is 256 clocks.
